tag_sched: RTL and testbench

TAG_SCHED -- requirements
Module: tag_sched

---
 rtl/tag_sched.sv | 114 +++++++++++
 tb/tb_tag_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_sched.sv
// Arbitrates store and load requests onto one shared, pipelined tag engine.
// One operation in flight; the result is a store tag or a load mismatch flag.
module tag_sched #(
  parameter int DATA_SIZE   = 32,
  parameter int TAG_SIZE    = 8,
  parameter int ENG_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_req,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic                 wr_gnt,
  input  logic                 ld_req,
  input  logic [DATA_SIZE-1:0] ld_data,
  input  logic [TAG_SIZE-1:0]  ld_tag,
  output logic                 ld_gnt,
  output logic [DATA_SIZE-1:0] eng_data,
  input  logic [TAG_SIZE-1:0]  eng_tag,
  output logic                 wr_done,
  output logic [TAG_SIZE-1:0]  wr_tag_out,
  output logic                 ld_done,
  output logic                 ld_mismatch,
  input  logic                 mm_clr,
  output logic [15:0]          mm_count,
  output logic                 busy
);

  localparam int CNT_W = (ENG_LATENCY < 1) ? 1 : $clog2(ENG_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENG_LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 cur_ld;
  logic                 last_ld;
  logic [TAG_SIZE-1:0]  cap_tag;
  logic                 req_any;
  logic                 pick_ld;

  // Load wins only when alone or when the store path was served last.
  assign req_any = wr_req | ld_req;
  assign pick_ld = ld_req & (~wr_req | ~last_ld);

  // NOTE: grants are combinational so the requester sees gnt in the same cycle
  // its request is accepted; they are gated by reset so nothing leaks out early.
  assign wr_gnt = reset_n & (state == IDLE) & req_any & ~pick_ld;
  assign ld_gnt = reset_n & (state == IDLE) & pick_ld;
  assign busy   = (state != IDLE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_ld      <= 1'b0;
      last_ld     <= 1'b1;
      cap_tag     <= '0;
      eng_data    <= '0;
      wr_done     <= 1'b0;
      ld_done     <= 1'b0;
      wr_tag_out  <= '0;
      ld_mismatch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_done <= 1'b0;
          ld_done <= 1'b0;
          if (req_any) begin
            cur_ld   <= pick_ld;
            last_ld  <= pick_ld;
            eng_data <= pick_ld ? ld_data : wr_data;
            cap_tag  <= ld_tag;
            cnt      <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state <= DONE;
            if (cur_ld) begin
              ld_done     <= 1'b1;
              ld_mismatch <= (eng_tag != cap_tag);
            end else begin
              wr_done    <= 1'b1;
              wr_tag_out <= eng_tag;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          wr_done <= 1'b0;
          ld_done <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mismatch counter: clear has priority, increment saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mm_count <= '0;
    end else if (mm_clr) begin
      mm_count <= '0;
    end else if ((state == DONE) && ld_done && ld_mismatch && (mm_count != 16'hFFFF)) begin
      mm_count <= mm_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tag_sched.sv
// Scoreboard bench for tag_sched with a byte-XOR pipelined tag engine model.
module tb_tag_sched;
  localparam int DW  = 32;
  localparam int TW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_req = 1'b0, ld_req = 1'b0, mm_clr = 1'b0;
  logic [DW-1:0] wr_data = '0, ld_data = '0;
  logic [TW-1:0] ld_tag = '0;
  logic          wr_gnt, ld_gnt, wr_done, ld_done, ld_mismatch, busy;
  logic [DW-1:0] eng_data;
  logic [TW-1:0] eng_tag, wr_tag_out;
  logic [15:0]   mm_count;

  always #5 clk = ~clk;

  tag_sched #(.DATA_SIZE(DW), .TAG_SIZE(TW), .ENG_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .ld_req(ld_req), .ld_data(ld_data), .ld_tag(ld_tag), .ld_gnt(ld_gnt),
    .eng_data(eng_data), .eng_tag(eng_tag),
    .wr_done(wr_done), .wr_tag_out(wr_tag_out),
    .ld_done(ld_done), .ld_mismatch(ld_mismatch),
    .mm_clr(mm_clr), .mm_count(mm_count), .busy(busy)
  );

  function automatic logic [TW-1:0] xtag(input logic [DW-1:0] d);
    return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  // Tag engine: LAT register stages, then XOR of the bytes.
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= eng_data;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign eng_tag = xtag(pipe[LAT-1]);

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit           is_ld;
    logic [TW-1:0] tag;
    bit           mm;
    int           gcyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   done_cnt = 0;
  int   last_g = 0;
  int   busy_until = -1;

  // Monitor: push expectation on grant, pop and compare on done.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_until = -1;
    end else begin
      if (cyc > last_g && cyc <= busy_until) check("busy_in_flight", busy, 1);
      if (wr_gnt && ld_gnt) check("dual_gnt", 1, 0);
      if ((wr_gnt || ld_gnt) && busy) check("gnt_while_busy", 1, 0);
      if (wr_gnt || ld_gnt) begin
        mon_e.is_ld = ld_gnt;
        mon_e.tag   = xtag(ld_gnt ? ld_data : wr_data);
        mon_e.mm    = ld_gnt && (mon_e.tag != ld_tag);
        mon_e.gcyc  = cyc;
        exp_q.push_back(mon_e);
        last_g     = cyc;
        busy_until = cyc + LAT + 2;
      end
      if (wr_done || ld_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_kind", ld_done, mon_e.is_ld);
          check("done_latency", cyc - mon_e.gcyc, LAT + 2);
          if (mon_e.is_ld) check("ld_mismatch", ld_mismatch, mon_e.mm);
          else             check("wr_tag_out", wr_tag_out, mon_e.tag);
        end
      end
    end
  end

  task automatic wait_gnt(input bit is_ld);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = is_ld ? ld_gnt : wr_gnt;
    end
    if (!got) check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = wr_done | ld_done;
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  // One complete operation; returns one cycle after DONE, past the edge.
  task automatic run_op(input bit is_ld, input logic [DW-1:0] d, input logic [TW-1:0] t);
    @(posedge clk); #1;
    if (is_ld) begin ld_req = 1'b1; ld_data = d; ld_tag = t; end
    else       begin wr_req = 1'b1; wr_data = d; end
    wait_gnt(is_ld);
    @(posedge clk); #1;
    wr_req = 1'b0;
    ld_req = 1'b0;
    wait_done();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_wr_gnt"},      wr_gnt, 0);
    check({pfx, "_ld_gnt"},      ld_gnt, 0);
    check({pfx, "_wr_done"},     wr_done, 0);
    check({pfx, "_ld_done"},     ld_done, 0);
    check({pfx, "_ld_mismatch"}, ld_mismatch, 0);
    check({pfx, "_busy"},        busy, 0);
    check({pfx, "_eng_data"},    eng_data, 0);
    check({pfx, "_wr_tag_out"},  wr_tag_out, 0);
    check({pfx, "_mm_count"},    mm_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gk[3];
    int gc[3];
    int ng;
    int dc;

    // Reset state, with both requests raised to confirm grants stay low.
    wr_req = 1'b1;
    ld_req = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    wr_req = 1'b0;
    ld_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention from reset: store wins first tie, then alternate.
    @(posedge clk); #1;
    wr_req = 1'b1; wr_data = 32'hDEADBEEF;
    ld_req = 1'b1; ld_data = 32'h01020304; ld_tag = xtag(32'h01020304);
    ng = 0;
    for (int n = 0; n < 40 && ng < 3; n++) begin
      @(negedge clk);
      if (wr_gnt || ld_gnt) begin
        gk[ng] = ld_gnt;
        gc[ng] = cyc;
        ng++;
      end
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
    ld_req = 1'b0;
    check("cont_grants", ng, 3);
    check("cont_g0_store", gk[0], 0);
    check("cont_g1_load", gk[1], 1);
    check("cont_g2_store", gk[2], 0);
    check("cont_gap01", gc[1] - gc[0], LAT + 3);
    check("cont_gap12", gc[2] - gc[1], LAT + 3);
    wait_done();
    @(posedge clk); #1;
    check("cont_mm_count", mm_count, 0);

    // Store and loads.
    run_op(1'b0, 32'h11223344, 8'h00);
    check("store_tag", wr_tag_out, 32'h44);
    run_op(1'b1, 32'h11223344, 8'h44);
    check("ld_match_flag", ld_mismatch, 0);
    check("ld_match_count", mm_count, 0);
    run_op(1'b1, 32'h11223344, 8'h45);
    check("ld_mm_flag", ld_mismatch, 1);
    check("ld_mm_count", mm_count, 1);

    // Saturation: preload just below the ceiling, then two more mismatches.
    force dut.mm_count = 16'hFFFE;
    #1;
    release dut.mm_count;
    run_op(1'b1, 32'hCAFEF00D, 8'h00);
    check("sat_reach", mm_count, 16'hFFFF);
    run_op(1'b1, 32'hCAFEF00D, 8'h00);
    check("sat_hold", mm_count, 16'hFFFF);

    // Clear during a mismatching load's DONE cycle beats the increment.
    @(posedge clk); #1;
    ld_req = 1'b1; ld_data = 32'h55AA55AA; ld_tag = 8'h01;
    wait_gnt(1'b1);
    @(posedge clk); #1;
    ld_req = 1'b0;
    wait_done();
    mm_clr = 1'b1;
    @(posedge clk); #1;
    mm_clr = 1'b0;
    check("clr_wins", mm_count, 0);

    // Reset mid-WAIT aborts the operation.
    run_op(1'b1, 32'h11223344, 8'h45);
    check("pre_abort_count", mm_count, 1);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_data = 32'hA5A50F0F;
    wait_gnt(1'b0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", busy, 1);
    dc = done_cnt;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("abort");
    wr_req = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_gnt_in_reset", wr_gnt, 0);
    check("abort_no_done_in_reset", wr_done | ld_done, 0);
    wr_req = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_done", done_cnt, dc);
    run_op(1'b0, 32'h11223344, 8'h00);
    check("post_reset_store", wr_tag_out, 32'h44);
    check("post_reset_done_cnt", done_cnt, dc + 1);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
